// File: rtl/ssd_pkg.sv
// ---------------------------------------------------------------------------
// ssd_pkg
// Shared definitions for the seven-segment display blocks.
//   MAX_DIGITS   : largest digit count a scan controller may be built with
//   DIGIT_IDX_W  : width of a digit index able to address MAX_DIGITS digits
//   SEG_BLANK    : high-active segment pattern with every segment dark
//   hex_to_seg() : nibble -> high-active glyph, bit order {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
package ssd_pkg;

  localparam int unsigned MAX_DIGITS  = 8;
  localparam int unsigned DIGIT_IDX_W = 3;

  localparam logic [6:0] SEG_BLANK = 7'b000_0000;

  // Standard hex glyphs; b and d are drawn lower-case so they differ from 8 and 0.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] glyph;
    case (nibble)
      4'h0:    glyph = 7'b011_1111;
      4'h1:    glyph = 7'b000_0110;
      4'h2:    glyph = 7'b101_1011;
      4'h3:    glyph = 7'b100_1111;
      4'h4:    glyph = 7'b110_0110;
      4'h5:    glyph = 7'b110_1101;
      4'h6:    glyph = 7'b111_1101;
      4'h7:    glyph = 7'b000_0111;
      4'h8:    glyph = 7'b111_1111;
      4'h9:    glyph = 7'b110_1111;
      4'hA:    glyph = 7'b111_0111;
      4'hB:    glyph = 7'b111_1100;
      4'hC:    glyph = 7'b011_1001;
      4'hD:    glyph = 7'b101_1110;
      4'hE:    glyph = 7'b111_1001;
      4'hF:    glyph = 7'b111_0001;
      default: glyph = SEG_BLANK;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// ---------------------------------------------------------------------------
// ssd_hex_decoder
// Combinational hex-to-seven-segment decoder (high-active glyph).
//   nibble_i : 4-bit hex value
//   seg_o    : {g,f,e,d,c,b,a}, 1 = segment lit
// ---------------------------------------------------------------------------
module ssd_hex_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/ssd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// ssd_scan_ctrl
// Multiplexed N-digit seven-segment scan controller with decimal points,
// per-digit blanking, PWM brightness and frame-synchronous (tear-free)
// display updates.
//
// Ports
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   number      : 4*NUM_DIGITS hex nibbles, nibble 0 = rightmost digit
//   dp_in       : decimal point per digit, 1 = lit
//   blank_in    : per-digit force-blank, 1 = dark
//   load        : 1-cycle strobe capturing number/dp_in/blank_in
//   brightness  : PWM duty level, 0 = 1/2**BRIGHT_W, all ones = 100 %
//   seg         : segments {g,f,e,d,c,b,a}
//   dp          : decimal point segment
//   an          : digit enables, one-hot or all off
//   frame_start : 1-cycle pulse on the first cycle digit 0 is presented
//
// seg/dp/an are low-active when ACTIVE_LOW = 1, high-active otherwise;
// frame_start is always a high-active pulse.
//
// Build option: define SSD_LZB_EN to enable leading-zero blanking.
// ---------------------------------------------------------------------------
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_LOG2 = 18,
  parameter int unsigned BRIGHT_W     = 4,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [4*NUM_DIGITS-1:0]   number,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     blank_in,
  input  logic                      load,
  input  logic [BRIGHT_W-1:0]       brightness,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      frame_start
);

  localparam int unsigned IDX_W = DIGIT_IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  // Physical OFF levels; XOR with these converts high-active to pin polarity.
  localparam logic [6:0]            SEG_OFF = ACTIVE_LOW ? 7'b111_1111 : 7'b000_0000;
  localparam logic                  DP_OFF  = ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{ACTIVE_LOW}};

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [REFRESH_LOG2-1:0] slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0]        digit_idx_q, digit_idx_d;

  logic [4*NUM_DIGITS-1:0] pend_num_q, pend_num_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;

  logic [4*NUM_DIGITS-1:0] act_num_q, act_num_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d;

  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_start_q, frame_start_d;

  // -------------------------------------------------------------------------
  // Combinational helpers
  // -------------------------------------------------------------------------
  logic                    slot_tc_s;
  logic                    frame_end_s;
  logic [BRIGHT_W-1:0]     phase_s;
  logic                    pwm_on_s;
  logic [3:0]              cur_nibble_s;
  logic                    cur_dp_s;
  logic                    cur_blank_s;
  logic                    suppress_s;
  logic                    an_on_s;
  logic [6:0]              glyph_s;
  logic [6:0]              seg_hi_s;
  logic                    dp_hi_s;
  logic [NUM_DIGITS-1:0]   an_hi_s;

  // Decoder for the digit currently being scanned
  ssd_hex_decoder u_hex_decoder (
    .nibble_i (cur_nibble_s),
    .seg_o    (glyph_s)
  );

  // Slot counter and digit index next-state
  always_comb begin
    slot_tc_s   = &slot_cnt_q;
    frame_end_s = slot_tc_s && (digit_idx_q == LAST_IDX);
    slot_cnt_d  = slot_cnt_q + REFRESH_LOG2'(1);
    digit_idx_d = digit_idx_q;
    if (frame_end_s) begin
      digit_idx_d = '0;
    end else if (slot_tc_s) begin
      digit_idx_d = digit_idx_q + IDX_W'(1);
    end else begin
      digit_idx_d = digit_idx_q;
    end
  end

  // Pending captures every load; active only moves at the frame boundary, and
  // taking pend_*_d there lets a coinciding load go straight to active.
  always_comb begin
    pend_num_d   = pend_num_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    act_num_d    = act_num_q;
    act_dp_d     = act_dp_q;
    act_blank_d  = act_blank_q;
    if (load) begin
      pend_num_d   = number;
      pend_dp_d    = dp_in;
      pend_blank_d = blank_in;
    end else begin
      pend_num_d   = pend_num_q;
      pend_dp_d    = pend_dp_q;
      pend_blank_d = pend_blank_q;
    end
    if (frame_end_s) begin
      act_num_d   = pend_num_d;
      act_dp_d    = pend_dp_d;
      act_blank_d = pend_blank_d;
    end else begin
      act_num_d   = act_num_q;
      act_dp_d    = act_dp_q;
      act_blank_d = act_blank_q;
    end
  end

  // Select the current digit's data, apply PWM, blanking and zero suppression
  always_comb begin
    cur_nibble_s = 4'(act_num_q >> {digit_idx_q, 2'b00});
    cur_dp_s     = 1'(act_dp_q >> digit_idx_q);
    cur_blank_s  = 1'(act_blank_q >> digit_idx_q);

    // PWM phase is the top BRIGHT_W bits of the slot position
    phase_s  = slot_cnt_q[REFRESH_LOG2-1 -: BRIGHT_W];
    pwm_on_s = (phase_s <= brightness);

`ifdef SSD_LZB_EN
    // A digit is a leading zero when it and every digit above it are zero;
    // digit 0 is never suppressed so a zero value still shows "0".
    suppress_s = (digit_idx_q != '0) &&
                 ((act_num_q >> {digit_idx_q, 2'b00}) == '0);
`else
    suppress_s = 1'b0;
`endif

    // A suppressed digit keeps its anode only to show a requested dp
    an_on_s  = pwm_on_s && !cur_blank_s && (!suppress_s || cur_dp_s);
    seg_hi_s = (an_on_s && !suppress_s) ? glyph_s : SEG_BLANK;
    dp_hi_s  = an_on_s && cur_dp_s;
    an_hi_s  = an_on_s ? (NUM_DIGITS'(1'b1) << digit_idx_q) : '0;

    seg_d         = seg_hi_s ^ SEG_OFF;
    dp_d          = dp_hi_s ^ DP_OFF;
    an_d          = an_hi_s ^ AN_OFF;
    frame_start_d = (slot_cnt_q == '0) && (digit_idx_q == '0);
  end

  // Scan counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q  <= '0;
      digit_idx_q <= '0;
    end else begin
      slot_cnt_q  <= slot_cnt_d;
      digit_idx_q <= digit_idx_d;
    end
  end

  // Pending and active display data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_num_q   <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      act_num_q    <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '0;
    end else begin
      pend_num_q   <= pend_num_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      act_num_q    <= act_num_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
    end
  end

  // Output registers, reset to the OFF level of the pin polarity
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q         <= SEG_OFF;
      dp_q          <= DP_OFF;
      an_q          <= AN_OFF;
      frame_start_q <= 1'b0;
    end else begin
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ssd_scan_ctrl
// Directed + randomized bench for ssd_scan_ctrl with NUM_DIGITS=4,
// REFRESH_LOG2=4, BRIGHT_W=2, ACTIVE_LOW=1. The reference model tracks time
// as a plain cycle count since reset and derives slot/digit/frame from it.
// ---------------------------------------------------------------------------
module tb_ssd_scan_ctrl;

  localparam int N     = 4;
  localparam int SLOT  = 16;
  localparam int FRAME = SLOT * N;
  localparam int PH_LEN = SLOT / 4;   // 2**BRIGHT_W phases per slot

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] number;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        load;
  logic [1:0]  brightness;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;

  ssd_scan_ctrl #(
    .NUM_DIGITS   (4),
    .REFRESH_LOG2 (4),
    .BRIGHT_W     (2),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .number      (number),
    .dp_in       (dp_in),
    .blank_in    (blank_in),
    .load        (load),
    .brightness  (brightness),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int          cyc;                    // clock edges since reset release
  logic [15:0] a_num, p_num;
  logic [3:0]  a_dp, p_dp, a_bl, p_bl;
  logic [6:0]  glyph [16];             // high-active glyphs
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_an;
  logic        e_fs;
  int          lit_cnt;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  // Expected pins for the scan position 'cyc' with the current active data
  task automatic compute_exp();
    int   slot;
    int   dig;
    logic lit;
    logic supp;
    logic vis;
    slot = cyc % SLOT;
    dig  = (cyc / SLOT) % N;
    lit  = (slot / PH_LEN) <= int'(brightness);
    supp = 1'b0;
`ifdef SSD_LZB_EN
    supp = (dig != 0) && ((a_num >> (4 * dig)) == 16'h0000);
`endif
    vis   = lit && !a_bl[dig] && (!supp || a_dp[dig]);
    e_an  = vis ? ~(4'b0001 << dig) : 4'b1111;
    e_seg = (vis && !supp) ? ~glyph[a_num[4*dig +: 4]] : 7'b111_1111;
    e_dp  = !(vis && a_dp[dig]);
    e_fs  = (cyc % FRAME) == 0;
  endtask

  task automatic model_reset();
    cyc   = 0;
    a_num = 16'h0000; p_num = 16'h0000;
    a_dp  = 4'h0;     p_dp  = 4'h0;
    a_bl  = 4'h0;     p_bl  = 4'h0;
  endtask

  // One clock: predict, advance model with sampled inputs, compare after the edge
  task automatic step();
    compute_exp();
    @(posedge clk);
    if (load) begin
      p_num = number; p_dp = dp_in; p_bl = blank_in;
    end
    if ((cyc % FRAME) == FRAME - 1) begin
      a_num = p_num; a_dp = p_dp; a_bl = p_bl;
    end
    cyc++;
    #1;
    chk("seg", {9'h000, seg}, {9'h000, e_seg});
    chk("dp", {15'h0000, dp}, {15'h0000, e_dp});
    chk("an", {12'h000, an}, {12'h000, e_an});
    chk("frame_start", {15'h0000, frame_start}, {15'h0000, e_fs});
  endtask

  task automatic do_load(input logic [15:0] n, input logic [3:0] d, input logic [3:0] b);
    number = n; dp_in = d; blank_in = b; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic to_frame_start();
    while ((cyc % FRAME) != 0) step();
  endtask

  initial begin
    glyph[0]  = 7'h3F; glyph[1]  = 7'h06; glyph[2]  = 7'h5B; glyph[3]  = 7'h4F;
    glyph[4]  = 7'h66; glyph[5]  = 7'h6D; glyph[6]  = 7'h7D; glyph[7]  = 7'h07;
    glyph[8]  = 7'h7F; glyph[9]  = 7'h6F; glyph[10] = 7'h77; glyph[11] = 7'h7C;
    glyph[12] = 7'h39; glyph[13] = 7'h5E; glyph[14] = 7'h79; glyph[15] = 7'h71;

    rst_n = 1'b0; number = 16'h0000; dp_in = 4'h0; blank_in = 4'h0;
    load = 1'b0; brightness = 2'b11;
    model_reset();

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst_an", {12'h000, an}, 16'h000F);
    chk("rst_seg", {9'h000, seg}, 16'h007F);
    chk("rst_dp", {15'h0000, dp}, 16'h0001);
    chk("rst_fs", {15'h0000, frame_start}, 16'h0000);
    #2 rst_n = 1'b1;

    // 1: no load, digit rotation and frame_start cadence
    step();
    chk("t1_an_first", {12'h000, an}, 16'h000E);
    chk("t1_seg_zero", {9'h000, seg}, 16'h0040);
    repeat (16) step();
    chk("t1_an_second", {12'h000, an}, 16'h000D);
    repeat (140) step();

    // 2: mid-frame load shows only from the next frame
    while ((cyc % FRAME) != 20) step();
    do_load(16'h12AF, 4'h0, 4'h0);
    repeat (10) step();
    to_frame_start();
    step();
    chk("t2_digit0_F", {9'h000, seg}, 16'h000E);
    repeat (47) step();
    step();
    chk("t2_digit3_1", {9'h000, seg}, 16'h0079);

    // 3: brightness extremes, counted over one full frame
    brightness = 2'b00;
    to_frame_start();
    lit_cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (an != 4'hF) lit_cnt++;
    end
    chk("t3_lit_min", 16'(lit_cnt), 16'd16);
    brightness = 2'b11;
    lit_cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (an != 4'hF) lit_cnt++;
    end
    chk("t3_lit_max", 16'(lit_cnt), 16'd64);
    brightness = 2'b01;
    repeat (70) step();
    brightness = 2'b11;

    // 4: blanking and decimal point
    do_load(16'h8421, 4'b0001, 4'b0100);
    repeat (2 * FRAME) step();

    // 5: leading zeros (behaviour depends on SSD_LZB_EN)
    do_load(16'h0050, 4'h0, 4'h0);
    repeat (FRAME + 70) step();
    do_load(16'h0000, 4'b0100, 4'h0);
    repeat (FRAME + 70) step();
    do_load(16'h0000, 4'h0, 4'h0);
    repeat (FRAME + 70) step();

    // Load coinciding with the frame boundary, then back-to-back loads
    while ((cyc % FRAME) != FRAME - 1) step();
    do_load(16'h3C7E, 4'b1010, 4'h0);
    step();
    repeat (20) step();
    do_load(16'h1111, 4'h0, 4'h0);
    do_load(16'hBEEF, 4'h1, 4'h0);
    repeat (FRAME + 10) step();

    // Randomized loads and brightness
    for (int it = 0; it < 30; it++) begin
      if ((it % 6) == 5) begin
        while ((cyc % FRAME) != FRAME - 1) step();
      end else begin
        repeat ($urandom_range(1, 90)) step();
      end
      brightness = 2'($urandom_range(0, 3));
      do_load(16'($urandom), 4'($urandom), 4'($urandom_range(0, 15) & 4'h5));
    end
    repeat (2 * FRAME) step();

    // 6: asynchronous reset mid-slot on digit 2
    brightness = 2'b11;
    while ((cyc % FRAME) != 37) step();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_an_off", {12'h000, an}, 16'h000F);
    chk("t6_seg_off", {9'h000, seg}, 16'h007F);
    chk("t6_dp_off", {15'h0000, dp}, 16'h0001);
    chk("t6_fs_low", {15'h0000, frame_start}, 16'h0000);
    @(posedge clk); #3;
    rst_n = 1'b1;
    model_reset();
    step();
    chk("t6_restart_an", {12'h000, an}, 16'h000E);
    chk("t6_restart_fs", {15'h0000, frame_start}, 16'h0001);
    repeat (FRAME + 5) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
